// File: rtl/frame_buffer_arbiter.sv
// Frame-buffer port arbiter: a small camera write FIFO and a single-pixel reader share one
// synchronous frame-buffer port.
//   state   | meaning
//   IDLE    | port free, arbitrating
//   WR      | MEM_WE high for the popped FIFO entry, arbitrating
//   RD_WAIT | read address on the port, waiting for MEM_RDATA
//   RD_DONE | RD_VALID pulse, arbitrating (reads excluded)
module frame_buffer_arbiter #(
  parameter int WIDTH      = 176,
  parameter int HEIGHT     = 144,
  parameter int FIFO_DEPTH = 4,
  parameter int HIGH_WATER = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        vsync_i,
  input  logic        cam_we_i,
  input  logic [7:0]  cam_x_i,
  input  logic [7:0]  cam_y_i,
  input  logic [7:0]  cam_data_i,
  input  logic        rd_req_i,
  input  logic [7:0]  rd_x_i,
  input  logic [7:0]  rd_y_i,
  output logic [7:0]  rd_data_o,
  output logic        rd_valid_o,
  output logic [14:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  output logic        mem_we_o,
  input  logic [7:0]  mem_rdata_i,
  output logic        overflow_o,
  output logic [2:0]  fifo_level_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [8:0]  W9    = 9'(WIDTH);
  localparam logic [8:0]  H9    = 9'(HEIGHT);
  localparam logic [2:0]  DEPTH = 3'(FIFO_DEPTH);
  localparam logic [2:0]  HW    = 3'(HIGH_WATER);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RD_DONE} state_t;

  state_t         state_q;
  logic [22:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]     level_q;
  logic           overflow_q, vsync_q;
  logic [7:0]     rd_data_q, mem_wdata_q;
  logic           rd_valid_q, mem_we_q;
  logic [14:0]    mem_addr_q;

  logic [14:0] cam_addr, rd_addr;
  logic        cam_in_range, rd_in_range, push, drop, pop;
  logic        arb_en, wr_hi, non_empty, rd_ok, grant_wr, grant_rd, vsync_rise;

  // Full 15-bit product: 143*176+175 = 25343 must not wrap.
  assign cam_addr = 15'(cam_y_i) * 15'(WIDTH) + 15'(cam_x_i);
  assign rd_addr  = 15'(rd_y_i) * 15'(WIDTH) + 15'(rd_x_i);

  assign cam_in_range = ({1'b0, cam_x_i} < W9) && ({1'b0, cam_y_i} < H9);
  assign rd_in_range  = ({1'b0, rd_x_i} < W9) && ({1'b0, rd_y_i} < H9);

  // Fullness is judged on the level at cycle start, so a same-cycle pop never frees a slot.
  assign push = cam_we_i && cam_in_range && (level_q < DEPTH);
  assign drop = cam_we_i && cam_in_range && !(level_q < DEPTH);

  assign arb_en    = (state_q != RD_WAIT);
  assign wr_hi     = (level_q >= HW);
  assign non_empty = (level_q != 3'd0);
  assign rd_ok     = rd_req_i && (state_q != RD_DONE);
  assign grant_wr  = arb_en && non_empty && (wr_hi || !rd_ok);
  assign grant_rd  = arb_en && rd_ok && !(wr_hi && non_empty);
  assign pop       = grant_wr;
  assign vsync_rise = vsync_i && !vsync_q;

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= {cam_addr, cam_data_i};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= 3'd0;
      overflow_q  <= 1'b0;
      vsync_q     <= 1'b0;
      rd_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
      mem_addr_q  <= 15'd0;
      mem_wdata_q <= 8'h00;
      mem_we_q    <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      mem_we_q   <= 1'b0;
      vsync_q    <= vsync_i;
      // A drop in the clearing cycle wins over the VSYNC clear.
      overflow_q <= drop || (overflow_q && !vsync_rise);
      level_q    <= level_q + {2'b00, push} - {2'b00, pop};
      if (push) wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;

      if (state_q == RD_WAIT) begin
        rd_data_q  <= mem_rdata_i;
        rd_valid_q <= 1'b1;
        state_q    <= RD_DONE;
      end else if (grant_wr) begin
        mem_addr_q  <= fifo_q[rd_ptr_q][22:8];
        mem_wdata_q <= fifo_q[rd_ptr_q][7:0];
        mem_we_q    <= 1'b1;
        state_q     <= WR;
      end else if (grant_rd) begin
        if (rd_in_range) begin
          mem_addr_q <= rd_addr;
          state_q    <= RD_WAIT;
        end else begin
          rd_data_q  <= 8'h00;
          rd_valid_q <= 1'b1;
          state_q    <= RD_DONE;
        end
      end else begin
        state_q <= IDLE;
      end
    end
  end

  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_we_o     = mem_we_q;
  assign overflow_o   = overflow_q;
  assign fifo_level_o = level_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter: inputs change and outputs are checked on the
// falling edge; the frame-buffer model answers combinationally from MEM_ADDR.
module tb_frame_buffer_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync, cam_we, rd_req;
  logic [7:0]  cam_x, cam_y, cam_data, rd_x, rd_y;
  logic [7:0]  rd_data, mem_wdata, mem_rdata;
  logic        rd_valid, mem_we, overflow;
  logic [14:0] mem_addr;
  logic [2:0]  fifo_level;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr == 15'd25343) ? 8'h1C : (mem_addr[7:0] ^ {1'b0, mem_addr[14:8]});

  frame_buffer_arbiter dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .vsync_i      (vsync),
    .cam_we_i     (cam_we),
    .cam_x_i      (cam_x),
    .cam_y_i      (cam_y),
    .cam_data_i   (cam_data),
    .rd_req_i     (rd_req),
    .rd_x_i       (rd_x),
    .rd_y_i       (rd_y),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_we_o     (mem_we),
    .mem_rdata_i  (mem_rdata),
    .overflow_o   (overflow),
    .fifo_level_o (fifo_level)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Six back-to-back camera writes A0..A5 (addr 177+k, data 10h+k) with a reader holding
  // RD_REQ for addr 3; A5 meets a full FIFO.  Starts and ends on a falling edge in IDLE.
  task automatic burst(input logic vs_on_drop);
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) @(negedge clk);
      case (c)
        1: check("b_lvl_c1", 32'(fifo_level), 1);
        2: begin
          check("b_rdvalid_c2", 32'(rd_valid), 1);
          check("b_rddata_c2", 32'(rd_data), 3);
          check("b_lvl_c2", 32'(fifo_level), 2);
        end
        3: begin
          check("b_we_c3", 32'(mem_we), 1);
          check("b_addr_c3", 32'(mem_addr), 177);
          check("b_wdata_c3", 32'(mem_wdata), 32'h10);
          check("b_lvl_pushpop_c3", 32'(fifo_level), 2);
        end
        4: begin
          check("b_lvl_c4", 32'(fifo_level), 3);
          check("b_we_c4", 32'(mem_we), 0);
        end
        5: check("b_lvl_full_c5", 32'(fifo_level), 4);
        6: begin
          check("b_ovf_c6", 32'(overflow), 1);
          check("b_we_c6", 32'(mem_we), 1);
          check("b_addr_c6", 32'(mem_addr), 178);
          check("b_lvl_c6", 32'(fifo_level), 3);
        end
        7: begin
          check("b_we_hiwater_c7", 32'(mem_we), 1);
          check("b_addr_c7", 32'(mem_addr), 179);
          check("b_lvl_c7", 32'(fifo_level), 2);
        end
        8: begin
          check("b_we_rd_c8", 32'(mem_we), 0);
          check("b_addr_rd_c8", 32'(mem_addr), 3);
        end
        9: check("b_rdvalid_c9", 32'(rd_valid), 1);
        10: check("b_addr_c10", 32'(mem_addr), 180);
        11: check("b_addr_c11", 32'(mem_addr), 181);
        12: begin
          check("b_we_c12", 32'(mem_we), 0);
          check("b_lvl_c12", 32'(fifo_level), 0);
        end
        default: ;
      endcase
      cam_we   = (c <= 5);
      cam_x    = 8'(c + 1);
      cam_y    = 8'd1;
      cam_data = 8'(8'h10 + c);
      rd_req   = (c <= 8);
      rd_x     = 8'd3;
      rd_y     = 8'd0;
      vsync    = vs_on_drop && (c == 5);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; vsync = 1'b0; cam_we = 1'b0; rd_req = 1'b0;
    cam_x = 8'd0; cam_y = 8'd0; cam_data = 8'd0; rd_x = 8'd0; rd_y = 8'd0;
    #2;
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_level", 32'(fifo_level), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // single camera write (5,2) -> 357
    @(negedge clk);
    cam_we = 1'b1; cam_x = 8'd5; cam_y = 8'd2; cam_data = 8'hE0;
    @(negedge clk);
    check("wr_level_push", 32'(fifo_level), 1);
    cam_we = 1'b0;
    @(negedge clk);
    check("wr_mem_we", 32'(mem_we), 1);
    check("wr_mem_addr", 32'(mem_addr), 357);
    check("wr_mem_wdata", 32'(mem_wdata), 32'hE0);
    check("wr_level_pop", 32'(fifo_level), 0);
    @(negedge clk);
    check("wr_we_one_cycle", 32'(mem_we), 0);

    // corner read (175,143) -> 25343
    rd_req = 1'b1; rd_x = 8'd175; rd_y = 8'd143;
    @(negedge clk);
    check("rd_mem_addr", 32'(mem_addr), 25343);
    check("rd_we_low", 32'(mem_we), 0);
    check("rd_valid_early", 32'(rd_valid), 0);
    @(negedge clk);
    check("rd_valid", 32'(rd_valid), 1);
    check("rd_data", 32'(rd_data), 32'h1C);
    rd_req = 1'b0;
    @(negedge clk);
    check("rd_valid_pulse", 32'(rd_valid), 0);
    check("rd_data_hold", 32'(rd_data), 32'h1C);

    // out-of-range read, then out-of-range camera write
    rd_req = 1'b1; rd_x = 8'd176; rd_y = 8'd0;
    @(negedge clk);
    check("oor_rd_valid", 32'(rd_valid), 1);
    check("oor_rd_data", 32'(rd_data), 0);
    check("oor_no_mem", 32'(mem_addr), 25343);
    rd_req = 1'b0;
    cam_we = 1'b1; cam_x = 8'd0; cam_y = 8'd144; cam_data = 8'h55;
    @(negedge clk);
    check("oor_rd_pulse", 32'(rd_valid), 0);
    check("oor_wr_level", 32'(fifo_level), 0);
    check("oor_wr_ovf", 32'(overflow), 0);
    cam_we = 1'b0;
    @(negedge clk);
    check("oor_wr_no_we", 32'(mem_we), 0);

    // overflow, VSYNC clear, then VSYNC clear coincident with a drop
    burst(1'b0);
    check("ovf_sticky", 32'(overflow), 1);
    vsync = 1'b1;
    @(negedge clk);
    check("ovf_vsync_clear", 32'(overflow), 0);
    vsync = 1'b0;
    @(negedge clk);
    burst(1'b1);
    check("ovf_drop_beats_clear", 32'(overflow), 1);

    // reset while a read is in RD_WAIT with two FIFO entries
    @(negedge clk);
    cam_we = 1'b1; cam_x = 8'd7; cam_y = 8'd0; cam_data = 8'hA7;
    @(negedge clk);
    check("rr_level1", 32'(fifo_level), 1);
    cam_x = 8'd8; cam_data = 8'hA8;
    rd_req = 1'b1; rd_x = 8'd10; rd_y = 8'd1;
    @(negedge clk);
    check("rr_rdwait_addr", 32'(mem_addr), 186);
    check("rr_level2", 32'(fifo_level), 2);
    cam_we = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rr_level_rst", 32'(fifo_level), 0);
    check("rr_we_rst", 32'(mem_we), 0);
    check("rr_valid_rst", 32'(rd_valid), 0);
    check("rr_addr_rst", 32'(mem_addr), 0);
    check("rr_ovf_rst", 32'(overflow), 0);
    @(negedge clk);
    check("rr_no_valid", 32'(rd_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rr_regrant_addr", 32'(mem_addr), 186);
    check("rr_regrant_level", 32'(fifo_level), 0);
    @(negedge clk);
    check("rr_regrant_valid", 32'(rd_valid), 1);
    check("rr_regrant_data", 32'(rd_data), 32'hBA);
    rd_req = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
